// File: rtl/obi_hetic_cfg_mgr.sv
// OBI manager that programs / reads back one HETI interrupt-line config halfword per command.
// Optional rvalid timeout is compiled in with `define OBI_HETIC_CFG_TIMEOUT_EN.
module obi_hetic_cfg_mgr #(
  parameter int          NrIrqLines    = 64,
  parameter int          NrIrqPrios    = 32,
  parameter logic [31:0] BaseAddr      = 32'h0000_2000,
  parameter int          TimeoutCycles = 255,
  localparam int         PrioWidth     = $clog2(NrIrqPrios),
  localparam int         IrqWidth      = $clog2(NrIrqLines),
  localparam int         CfgWidth      = 6 + PrioWidth
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [IrqWidth-1:0] cmd_line_i,
  input  logic [1:0]          cmd_be_i,
  input  logic [CfgWidth-1:0] cmd_cfg_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_err_o,
  output logic [CfgWidth-1:0] rsp_cfg_o,
  output logic                obi_req_o,
  input  logic                obi_gnt_i,
  output logic [31:0]         obi_addr_o,
  output logic                obi_we_o,
  output logic [3:0]          obi_be_o,
  output logic [31:0]         obi_wdata_o,
  input  logic                obi_rvalid_i,
  input  logic [31:0]         obi_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e                state_reg, state_next;
  logic [31:0]           addr_reg;
  logic [3:0]            be_reg;
  logic [31:0]           wdata_reg;
  logic                  we_reg;
  logic                  odd_reg;
  logic                  rsp_err_reg;
  logic [CfgWidth-1:0]   rsp_cfg_reg;

  logic                  accept;
  logic                  line_ok;
  logic                  local_done;
  logic                  tmo_hit;
  logic [15:0]           cmd_hw;
  logic [15:0]           rd_hw;
  logic [1:0]            half_be;
  logic [CfgWidth-1:0]   rd_cfg;
  logic                  unused_rd_hw;

  assign accept     = cmd_valid_i && cmd_ready_o;
  assign line_ok    = 32'(cmd_line_i) < 32'(NrIrqLines);
  // Out-of-range lines and empty writes never touch the bus.
  assign local_done = !line_ok || (cmd_we_i && (cmd_be_i == 2'b00));

  assign cmd_hw  = {8'(cmd_cfg_i[CfgWidth-1:6]), 2'b00, cmd_cfg_i[5:0]};
  assign half_be = cmd_we_i ? cmd_be_i : 2'b11;

  assign rd_hw        = odd_reg ? obi_rdata_i[31:16] : obi_rdata_i[15:0];
  assign rd_cfg       = {rd_hw[8 +: PrioWidth], rd_hw[5:0]};
  assign unused_rd_hw = ^rd_hw;

`ifdef OBI_HETIC_CFG_TIMEOUT_EN
  localparam int TmoBits  = $clog2(TimeoutCycles + 1);
  localparam int TmoWidth = (TmoBits < 8) ? 8 : ((TmoBits > 16) ? 16 : TmoBits);

  logic [TmoWidth-1:0] tmo_cnt_reg;

  // Fires in the last permitted RESP cycle so DONE follows exactly TimeoutCycles RESP cycles.
  assign tmo_hit = (state_reg == RESP) && !obi_rvalid_i &&
                   (tmo_cnt_reg == TmoWidth'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_reg <= '0;
    end else if ((state_reg == REQ) && obi_gnt_i) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == RESP) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)                   state_next = local_done ? DONE : REQ;
      REQ:     if (obi_gnt_i)                state_next = RESP;
      RESP:    if (obi_rvalid_i || tmo_hit)  state_next = DONE;
      DONE:    if (rsp_ready_i)              state_next = IDLE;
      default:                               state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      be_reg      <= '0;
      wdata_reg   <= '0;
      we_reg      <= 1'b0;
      odd_reg     <= 1'b0;
      rsp_err_reg <= 1'b0;
      rsp_cfg_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg    <= BaseAddr + ((32'(cmd_line_i) >> 1) << 2);
        be_reg      <= cmd_line_i[0] ? {half_be, 2'b00} : {2'b00, half_be};
        wdata_reg   <= !cmd_we_i ? 32'd0 :
                       (cmd_line_i[0] ? {cmd_hw, 16'h0000} : {16'h0000, cmd_hw});
        we_reg      <= cmd_we_i;
        odd_reg     <= cmd_line_i[0];
        rsp_err_reg <= !line_ok;
        rsp_cfg_reg <= '0;
      end
      if (state_reg == RESP) begin
        if (obi_rvalid_i) begin
          if (!we_reg) rsp_cfg_reg <= rd_cfg;
        end else if (tmo_hit) begin
          rsp_err_reg <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready_o = (state_reg == IDLE);
  assign rsp_valid_o = (state_reg == DONE);
  assign obi_req_o   = (state_reg == REQ);
  assign rsp_err_o   = rsp_err_reg;
  assign rsp_cfg_o   = rsp_cfg_reg;
  assign obi_addr_o  = addr_reg;
  assign obi_we_o    = we_reg;
  assign obi_be_o    = be_reg;
  assign obi_wdata_o = wdata_reg;

endmodule
